// File: rtl/oled_fb_arbiter_pkg.sv
// Shared constants and encodings for the SSD1306 framebuffer arbiter.
package oled_fb_arbiter_pkg;
  localparam int OLED_FB_ADDR_WIDTH = 10;
  localparam int OLED_FB_DEPTH      = 1 << OLED_FB_ADDR_WIDTH;

  typedef enum logic {SERVE = 1'b0, CLEAR = 1'b1} state_t;
  typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} gnt_t;
endpackage

// File: rtl/oled_fb_ram.sv
// Single-port synchronous framebuffer RAM, read-first, 1-cycle registered read, no reset.
module oled_fb_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/oled_fb_arbiter.sv
// Framebuffer owner: round-robin display-read / host-write arbiter plus clear engine.
// Optional writer stall counter built when OLED_FB_ARB_STATS_EN is defined.
module oled_fb_arbiter
  import oled_fb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = OLED_FB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_fill_data,
  output logic                  o_busy,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic [15:0]           o_stall_count
);
  localparam int               DEPTH     = 1 << ADDR_WIDTH;
  localparam int               CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam state_t           RST_STATE = CLEAR_ON_RESET ? CLEAR : SERVE;

  state_t                  state_q, state_d;
  gnt_t                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   fill_q, fill_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rd_gnt, wr_gnt, wr_ready;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;
  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   rd_hold_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= RST_STATE;
    else          state_q <= state_d;
  end

  // Stage p0: arbitration, clear sequencing and RAM access select
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    last_d    = last_q;
    wr_ready  = 1'b0;
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = rd_addr_q;
    ram_wdata = i_wr_data;
    case (state_q)
      SERVE: begin
        wr_ready = !rd_pend_q || (last_q == GNT_READ);
        wr_gnt   = i_wr_valid && wr_ready;
        rd_gnt   = rd_pend_q && !wr_gnt;
        if (wr_gnt) begin
          ram_we   = 1'b1;
          ram_addr = i_wr_addr;
          last_d   = GNT_WRITE;
        end else if (rd_gnt) begin
          last_d = GNT_READ;
        end
        if (i_clear) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          cnt_d   = '0;
          fill_d  = i_fill_data;
        end
      end
      CLEAR: begin
        // Out of reset the engine spends one arming cycle before its first write
        if (busy_q) begin
          ram_we    = 1'b1;
          ram_addr  = cnt_q[ADDR_WIDTH-1:0];
          ram_wdata = fill_q;
          if (cnt_q == CNT_LAST) begin
            state_d = SERVE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
    rd_pend_d = (rd_pend_q && !rd_gnt) || i_rd_req;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q    <= GNT_WRITE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      fill_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      last_q    <= last_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      rd_pend_q <= rd_pend_d;
      if (i_rd_req) rd_addr_q <= i_rd_addr;
    end
  end

  oled_fb_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage p1: RAM output is live on the valid cycle, then held for the display
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1    <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      vld_p1 <= rd_gnt;
      if (vld_p1) rd_hold_q <= ram_rdata;
    end
  end

  assign o_rd_valid = vld_p1;
  assign o_rd_data  = vld_p1 ? ram_rdata : rd_hold_q;
  assign o_busy     = busy_q;
  assign o_wr_ready = wr_ready;

`ifdef OLED_FB_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_q <= '0;
    else if (i_wr_valid && !wr_ready && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end

  assign o_stall_count = stall_q;
`else
  assign o_stall_count = '0;
`endif
endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Directed bench for oled_fb_arbiter (default parameters, CLEAR_ON_RESET=1).
module tb_oled_fb_arbiter;
  import oled_fb_arbiter_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_clear = 1'b0;
  logic [7:0]  i_fill_data = 8'h00;
  logic        o_busy;
  logic        i_rd_req = 1'b0;
  logic [9:0]  i_rd_addr = 10'h000;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        i_wr_valid = 1'b0;
  logic [9:0]  i_wr_addr = 10'h000;
  logic [7:0]  i_wr_data = 8'h00;
  logic        o_wr_ready;
  logic [15:0] o_stall_count;

  int checks = 0;
  int errors = 0;

  oled_fb_arbiter dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (i_clear),
    .i_fill_data   (i_fill_data),
    .o_busy        (o_busy),
    .i_rd_req      (i_rd_req),
    .i_rd_addr     (i_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_rd_valid    (o_rd_valid),
    .i_wr_valid    (i_wr_valid),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .o_wr_ready    (o_wr_ready),
    .o_stall_count (o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (o_busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic do_read(input logic [9:0] a, output logic [7:0] d, output int lat);
    i_rd_req  = 1'b1;
    i_rd_addr = a;
    tick();
    i_rd_req = 1'b0;
    lat = 1;
    while (o_rd_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d = o_rd_data;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d, output int waitc);
    i_wr_valid = 1'b1;
    i_wr_addr  = a;
    i_wr_data  = d;
    waitc = 0;
    while (o_wr_ready !== 1'b1 && waitc < 3000) begin
      tick();
      waitc++;
    end
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", o_rd_valid); end
    checks++; if (o_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %02h want 00", o_rd_data); end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %0b want 0", o_wr_ready); end
    checks++; if (o_stall_count !== 16'h0000) begin errors++; $display("FAIL reset_stall got %04h want 0000", o_stall_count); end
  endtask

  task automatic test_reset_clear;
    int n, lat;
    logic [7:0] d;
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd511; addrs[2] = 10'd1023;
    i_rst_n = 1'b1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL release_busy_early got %0b want 0", o_busy); end
    tick();
    count_busy(n);
    checks++; if (n != 1024) begin errors++; $display("FAIL reset_clear_len got %0d want 1024", n); end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, lat);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_clear_data addr=%0d got %02h want 00", addrs[i], d); end
      checks++; if (lat != 2) begin errors++; $display("FAIL reset_clear_lat addr=%0d got %0d want 2", addrs[i], lat); end
    end
  endtask

  task automatic test_write_readback;
    int waitc, lat;
    logic [7:0] d;
    do_write(10'h123, 8'hA5, waitc);
    checks++; if (waitc != 0) begin errors++; $display("FAIL wr_idle_wait got %0d want 0", waitc); end
    do_read(10'h123, d, lat);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL readback got %02h want a5", d); end
    checks++; if (lat != 2) begin errors++; $display("FAIL readback_lat got %0d want 2", lat); end
    tick();
    checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %0b want 0", o_rd_valid); end
    checks++; if (o_rd_data !== 8'hA5) begin errors++; $display("FAIL rd_data_hold got %02h want a5", o_rd_data); end
  endtask

  // Entered with last grant READ and nothing pending (previous test ended with a read).
  task automatic test_contention;
    int idx, nrd;
    logic hs;
    gnt_t exp_gnt;
    logic [7:0] got [8];
    idx = 0;
    nrd = 0;
    for (int c = 0; c < 20; c++) begin
      i_rd_req   = (c % 2 == 0) && (c < 16);
      i_rd_addr  = 10'(c / 2);
      i_wr_valid = (c >= 1) && (idx < 8);
      i_wr_addr  = 10'(idx);
      i_wr_data  = 8'(8'h30 + idx);
      if (c >= 1 && c <= 16) begin
        exp_gnt = (c % 2 == 1) ? GNT_WRITE : GNT_READ;
        checks++;
        if (o_wr_ready !== (exp_gnt == GNT_WRITE)) begin
          errors++; $display("FAIL rr_grant cycle=%0d ready got %0b want %0b", c, o_wr_ready, exp_gnt == GNT_WRITE);
        end
      end
      hs = i_wr_valid && o_wr_ready;
      tick();
      if (hs) idx++;
      if (o_rd_valid === 1'b1 && nrd < 8) begin
        got[nrd] = o_rd_data;
        nrd++;
      end
    end
    i_rd_req = 1'b0;
    i_wr_valid = 1'b0;
    checks++; if (idx != 8) begin errors++; $display("FAIL rr_writes got %0d want 8", idx); end
    checks++; if (nrd != 8) begin errors++; $display("FAIL rr_reads got %0d want 8", nrd); end
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (j < nrd && got[j] !== 8'(8'h30 + j)) begin
        errors++; $display("FAIL rr_rdata idx=%0d got %02h want %02h", j, got[j], 8'(8'h30 + j));
      end
    end
  endtask

  task automatic test_clear_traffic;
    int n, ready_bad, lat;
    logic [15:0] s0, exp_delta;
    logic [7:0] d;
`ifdef OLED_FB_ARB_STATS_EN
    exp_delta = 16'd1024;
`else
    exp_delta = 16'd0;
`endif
    i_wr_valid  = 1'b1;
    i_wr_addr   = 10'h200;
    i_wr_data   = 8'h5A;
    i_clear     = 1'b1;
    i_fill_data = 8'hFF;
    checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL clear_start_hs ready got %0b want 1", o_wr_ready); end
    s0 = o_stall_count;
    tick();
    i_clear = 1'b0;
    n = 0;
    ready_bad = 0;
    while (o_busy === 1'b1 && n < 2000) begin
      if (o_wr_ready !== 1'b0) ready_bad++;
      i_rd_req    = (n == 100);
      i_rd_addr   = 10'h050;
      i_clear     = (n == 200);
      i_fill_data = 8'h11;
      n++;
      tick();
    end
    i_rd_req = 1'b0;
    i_clear  = 1'b0;
    checks++; if (n != 1024) begin errors++; $display("FAIL clear_len got %0d want 1024", n); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL clear_ready_low got %0d ready cycles want 0", ready_bad); end
    checks++;
    if (16'(o_stall_count - s0) !== exp_delta) begin
      errors++; $display("FAIL stall_delta got %0d want %0d", 16'(o_stall_count - s0), exp_delta);
    end
    tick();
    i_wr_valid = 1'b0;
    checks++; if (o_rd_valid !== 1'b1) begin errors++; $display("FAIL held_read_valid got %0b want 1", o_rd_valid); end
    checks++; if (o_rd_data !== 8'hFF) begin errors++; $display("FAIL held_read_data got %02h want ff", o_rd_data); end
    repeat (3) tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL second_clear_busy got %0b want 0", o_busy); end
    do_read(10'h3FF, d, lat);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL clear_fill_last got %02h want ff", d); end
    do_read(10'h200, d, lat);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL clear_overwrites_write got %02h want ff", d); end
  endtask

  task automatic test_reset_midclear;
    int n, lat;
    logic [7:0] d;
    i_clear     = 1'b1;
    i_fill_data = 8'h77;
    tick();
    i_clear = 1'b0;
    repeat (300) tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL midclear_busy got %0b want 1", o_busy); end
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", o_busy); end
    checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_valid got %0b want 0", o_rd_valid); end
    checks++; if (o_rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_rd_data got %02h want 00", o_rd_data); end
    checks++; if (o_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_ready got %0b want 0", o_wr_ready); end
    checks++; if (o_stall_count !== 16'h0000) begin errors++; $display("FAIL rst_mid_stall got %04h want 0000", o_stall_count); end
    tick();
    i_rst_n = 1'b1;
    tick();
    count_busy(n);
    checks++; if (n != 1024) begin errors++; $display("FAIL restart_clear_len got %0d want 1024", n); end
    do_read(10'd0, d, lat);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL restart_addr0 got %02h want 00", d); end
    do_read(10'd500, d, lat);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL restart_addr500 got %02h want 00", d); end
  endtask

  task automatic test_stats;
`ifdef OLED_FB_ARB_STATS_EN
    i_wr_valid = 1'b1;
    i_wr_addr  = 10'h001;
    i_wr_data  = 8'h01;
    for (int c = 0; c < 70000; c++) begin
      i_clear = (o_busy === 1'b0);
      tick();
    end
    i_clear = 1'b0;
    i_wr_valid = 1'b0;
    checks++; if (o_stall_count !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate got %04h want ffff", o_stall_count); end
`else
    checks++; if (o_stall_count !== 16'h0000) begin errors++; $display("FAIL stall_tied_zero got %04h want 0000", o_stall_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_clear();
    test_write_readback();
    test_contention();
    test_clear_traffic();
    test_reset_midclear();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
